vertex_ram_axil: RTL and testbench

VERTEX_RAM_AXIL -- requirements
Module: vertex_ram_axil

---
 rtl/gpu_axil_pkg.sv | 20 ++
 rtl/ram_1r1w_be.sv | 30 +++
 rtl/vertex_ram_axil.sv | 191 +++++++++++++++++++
 tb/tb_vertex_ram_axil.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_axil_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the vertex RAM slave
// and the fetch master.
package gpu_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/ram_1r1w_be.sv
// Simple dual-port word RAM: one byte-enabled write port, one registered read port.
// Contents are never reset; a same-address read and write in one cycle returns the old word.
module ram_1r1w_be #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_be,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b]) begin
                mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/vertex_ram_axil.sv
// AXI4-Lite slave serving vertex/colour words from a byte-enabled RAM.
// Define VERTEX_RAM_ADDR_CHECK_EN to answer out-of-range accesses with SLVERR instead of wrapping.
module vertex_ram_axil
    import gpu_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] awaddr_s,
    input  logic [2:0]            awprot_s,
    input  logic                  awvalid_s,
    output logic                  awready_s,
    input  logic [31:0]           wdata_s,
    input  logic [3:0]            wstrb_s,
    input  logic                  wvalid_s,
    output logic                  wready_s,
    output logic [1:0]            bresp_s,
    output logic                  bvalid_s,
    input  logic                  bready_s,
    input  logic [ADDR_WIDTH-1:0] araddr_s,
    input  logic [2:0]            arprot_s,
    input  logic                  arvalid_s,
    output logic                  arready_s,
    output logic [31:0]           rdata_s,
    output logic [1:0]            rresp_s,
    output logic                  rvalid_s,
    input  logic                  rready_s
);

    localparam int IDX_W = $clog2(DEPTH);

    rd_state_t rd_state, rd_state_next;
    wr_state_t wr_state, wr_state_next;

    logic                  ar_hs;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  commit;
    logic                  rd_err;
    logic                  wr_err;
    logic                  rd_err_q;
    logic [1:0]            bresp_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic [31:0]           ram_rdata;
    logic                  unused_inputs;

    // The final handshake may arrive with its half still on the bus, so mix captured and live values.
    assign wr_addr = (wr_state == W_HAVE_AW) ? aw_addr_q : awaddr_s;
    assign wr_data = (wr_state == W_HAVE_W)  ? w_data_q  : wdata_s;
    assign wr_strb = (wr_state == W_HAVE_W)  ? w_strb_q  : wstrb_s;

`ifdef VERTEX_RAM_ADDR_CHECK_EN
    assign rd_err = |(araddr_s >> (IDX_W + 2));
    assign wr_err = |(wr_addr >> (IDX_W + 2));
`else
    assign rd_err = 1'b0;
    assign wr_err = 1'b0;
`endif

    assign unused_inputs = ^{awprot_s, arprot_s, araddr_s, wr_addr};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state <= R_IDLE;
            rd_err_q <= 1'b0;
        end else begin
            rd_state <= rd_state_next;
            if (ar_hs) begin
                rd_err_q <= rd_err;
            end
        end
    end

    always_comb begin
        rd_state_next = rd_state;
        arready_s     = 1'b0;
        rvalid_s      = 1'b0;
        case (rd_state)
            R_IDLE: begin
                arready_s = 1'b1;
                if (arvalid_s) begin
                    rd_state_next = R_RESP;
                end
            end
            R_RESP: begin
                rvalid_s = 1'b1;
                if (rready_s) begin
                    rd_state_next = R_IDLE;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    assign ar_hs = arvalid_s && arready_s;

    // The RAM only reloads on a new AR, so rdata holds while the master stalls.
    assign rdata_s = (rvalid_s && !rd_err_q) ? ram_rdata : 32'h0;
    assign rresp_s = (rvalid_s && rd_err_q) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state  <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= 32'h0;
            w_strb_q  <= 4'h0;
            bresp_q   <= RESP_OKAY;
        end else begin
            wr_state <= wr_state_next;
            if (aw_hs) begin
                aw_addr_q <= awaddr_s;
            end
            if (w_hs) begin
                w_data_q <= wdata_s;
                w_strb_q <= wstrb_s;
            end
            if (commit) begin
                bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_comb begin
        wr_state_next = wr_state;
        awready_s     = 1'b0;
        wready_s      = 1'b0;
        bvalid_s      = 1'b0;
        commit        = 1'b0;
        case (wr_state)
            W_IDLE: begin
                awready_s = 1'b1;
                wready_s  = 1'b1;
                if (awvalid_s && wvalid_s) begin
                    commit        = 1'b1;
                    wr_state_next = W_RESP;
                end else if (awvalid_s) begin
                    wr_state_next = W_HAVE_AW;
                end else if (wvalid_s) begin
                    wr_state_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                wready_s = 1'b1;
                if (wvalid_s) begin
                    commit        = 1'b1;
                    wr_state_next = W_RESP;
                end
            end
            W_HAVE_W: begin
                awready_s = 1'b1;
                if (awvalid_s) begin
                    commit        = 1'b1;
                    wr_state_next = W_RESP;
                end
            end
            W_RESP: begin
                bvalid_s = 1'b1;
                if (bready_s) begin
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    assign aw_hs   = awvalid_s && awready_s;
    assign w_hs    = wvalid_s && wready_s;
    assign bresp_s = bvalid_s ? bresp_q : RESP_OKAY;

    ram_1r1w_be #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (commit && !wr_err),
        .wr_addr (wr_addr[IDX_W+1:2]),
        .wr_data (wr_data),
        .wr_be   (wr_strb),
        .rd_en   (ar_hs),
        .rd_addr (araddr_s[IDX_W+1:2]),
        .rd_data (ram_rdata)
    );

endmodule

// File: tb/tb_vertex_ram_axil.sv
// Directed self-checking bench for vertex_ram_axil (both VERTEX_RAM_ADDR_CHECK_EN builds).
module tb_vertex_ram_axil;
    import gpu_axil_pkg::*;

    localparam int ADDR_WIDTH = 32;
    localparam int DEPTH      = 256;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [ADDR_WIDTH-1:0] awaddr_s;
    logic [2:0]            awprot_s;
    logic                  awvalid_s;
    logic                  awready_s;
    logic [31:0]           wdata_s;
    logic [3:0]            wstrb_s;
    logic                  wvalid_s;
    logic                  wready_s;
    logic [1:0]            bresp_s;
    logic                  bvalid_s;
    logic                  bready_s;
    logic [ADDR_WIDTH-1:0] araddr_s;
    logic [2:0]            arprot_s;
    logic                  arvalid_s;
    logic                  arready_s;
    logic [31:0]           rdata_s;
    logic [1:0]            rresp_s;
    logic                  rvalid_s;
    logic                  rready_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vertex_ram_axil #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .awaddr_s  (awaddr_s),
        .awprot_s  (awprot_s),
        .awvalid_s (awvalid_s),
        .awready_s (awready_s),
        .wdata_s   (wdata_s),
        .wstrb_s   (wstrb_s),
        .wvalid_s  (wvalid_s),
        .wready_s  (wready_s),
        .bresp_s   (bresp_s),
        .bvalid_s  (bvalid_s),
        .bready_s  (bready_s),
        .araddr_s  (araddr_s),
        .arprot_s  (arprot_s),
        .arvalid_s (arvalid_s),
        .arready_s (arready_s),
        .rdata_s   (rdata_s),
        .rresp_s   (rresp_s),
        .rvalid_s  (rvalid_s),
        .rready_s  (rready_s)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input bit w_first, input logic [1:0] exp_resp);
        @(negedge clk);
        wdata_s  = data;
        wstrb_s  = strb;
        wvalid_s = 1'b1;
        if (w_first) begin
            @(posedge clk);
            #1;
            wvalid_s  = 1'b0;
            checkOutput("awready_after_w", awready_s, 1);
            checkOutput("wready_after_w", wready_s, 0);
            checkOutput("bvalid_early", bvalid_s, 0);
            awaddr_s  = addr;
            awvalid_s = 1'b1;
        end else begin
            awaddr_s  = addr;
            awvalid_s = 1'b1;
        end
        @(posedge clk);
        #1;
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        checkOutput("bvalid", bvalid_s, 1);
        checkOutput("bresp", bresp_s, exp_resp);
        bready_s = 1'b1;
        @(posedge clk);
        #1;
        bready_s = 1'b0;
        checkOutput("bvalid_clear", bvalid_s, 0);
    endtask

    task automatic axiRead(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        @(negedge clk);
        araddr_s  = addr;
        arvalid_s = 1'b1;
        checkOutput("arready", arready_s, 1);
        @(posedge clk);
        #1;
        arvalid_s = 1'b0;
        checkOutput("rvalid", rvalid_s, 1);
        checkOutput("rdata", rdata_s, exp_data);
        checkOutput("rresp", rresp_s, exp_resp);
        rready_s = 1'b1;
        @(posedge clk);
        #1;
        rready_s = 1'b0;
        checkOutput("rvalid_clear", rvalid_s, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        awaddr_s  = '0;
        awprot_s  = 3'h0;
        awvalid_s = 1'b0;
        wdata_s   = 32'h0;
        wstrb_s   = 4'h0;
        wvalid_s  = 1'b0;
        bready_s  = 1'b0;
        araddr_s  = '0;
        arprot_s  = 3'h0;
        arvalid_s = 1'b0;
        rready_s  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_arready", arready_s, 1);
        checkOutput("rst_awready", awready_s, 1);
        checkOutput("rst_wready", wready_s, 1);
        checkOutput("rst_rvalid", rvalid_s, 0);
        checkOutput("rst_bvalid", bvalid_s, 0);
        checkOutput("rst_rdata", rdata_s, 0);
        checkOutput("rst_rresp", rresp_s, 0);
        checkOutput("rst_bresp", bresp_s, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic write then read, 1-cycle latencies
        axiWrite(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, RESP_OKAY);
        axiRead(32'h10, 32'hDEADBEEF, RESP_OKAY);
        axiRead(32'h11, 32'hDEADBEEF, RESP_OKAY);

        // wstrb=0 is a no-op write that still responds
        axiWrite(32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, RESP_OKAY);
        axiRead(32'h10, 32'hDEADBEEF, RESP_OKAY);

        // W before AW with partial strobes
        axiWrite(32'h20, 32'h11223344, 4'hF, 1'b0, RESP_OKAY);
        axiWrite(32'h20, 32'h0000ABCD, 4'h3, 1'b1, RESP_OKAY);
        axiRead(32'h20, 32'h1122ABCD, RESP_OKAY);

        axiWrite(32'h24, 32'h12345678, 4'hF, 1'b0, RESP_OKAY);
        axiWrite(32'h24, 32'hAA0000BB, 4'h9, 1'b0, RESP_OKAY);
        axiRead(32'h24, 32'hAA3456BB, RESP_OKAY);

        // Stalled read response stays stable
        axiWrite(32'h08, 32'hCAFEF00D, 4'hF, 1'b0, RESP_OKAY);
        @(negedge clk);
        araddr_s  = 32'h08;
        arvalid_s = 1'b1;
        @(posedge clk);
        #1;
        arvalid_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("hold_rvalid", rvalid_s, 1);
            checkOutput("hold_rdata", rdata_s, 32'hCAFEF00D);
            checkOutput("hold_arready", arready_s, 0);
            @(posedge clk);
            #1;
        end
        rready_s = 1'b1;
        @(posedge clk);
        #1;
        rready_s = 1'b0;
        checkOutput("hold_release", rvalid_s, 0);

        // Same-cycle read and write to word 3 returns old data
        axiWrite(32'h0C, 32'h5, 4'hF, 1'b0, RESP_OKAY);
        @(negedge clk);
        araddr_s  = 32'h0C;
        arvalid_s = 1'b1;
        awaddr_s  = 32'h0C;
        awvalid_s = 1'b1;
        wdata_s   = 32'h9;
        wstrb_s   = 4'hF;
        wvalid_s  = 1'b1;
        @(posedge clk);
        #1;
        arvalid_s = 1'b0;
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        checkOutput("rbw_rvalid", rvalid_s, 1);
        checkOutput("rbw_rdata", rdata_s, 32'h5);
        checkOutput("rbw_bvalid", bvalid_s, 1);
        rready_s = 1'b1;
        bready_s = 1'b1;
        @(posedge clk);
        #1;
        rready_s = 1'b0;
        bready_s = 1'b0;
        axiRead(32'h0C, 32'h9, RESP_OKAY);

        // Out-of-range addresses
        axiWrite(32'h0, 32'h0BADF00D, 4'hF, 1'b0, RESP_OKAY);
        axiWrite(32'h4, 32'h66, 4'hF, 1'b0, RESP_OKAY);
`ifdef VERTEX_RAM_ADDR_CHECK_EN
        axiRead(32'(DEPTH * 4), 32'h0, RESP_SLVERR);
        axiWrite(32'(DEPTH * 4 + 4), 32'h77, 4'hF, 1'b0, RESP_SLVERR);
        axiRead(32'h4, 32'h66, RESP_OKAY);
`else
        axiRead(32'(DEPTH * 4), 32'h0BADF00D, RESP_OKAY);
        axiWrite(32'(DEPTH * 4 + 4), 32'h77, 4'hF, 1'b0, RESP_OKAY);
        axiRead(32'h4, 32'h77, RESP_OKAY);
`endif

        // Reset while a read response is pending
        @(negedge clk);
        araddr_s  = 32'h10;
        arvalid_s = 1'b1;
        @(posedge clk);
        #1;
        arvalid_s = 1'b0;
        checkOutput("prereset_rvalid", rvalid_s, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("reset_rvalid", rvalid_s, 0);
        checkOutput("reset_arready", arready_s, 1);
        checkOutput("reset_rdata", rdata_s, 0);
        @(negedge clk);
        reset_n = 1'b1;
        axiRead(32'h10, 32'hDEADBEEF, RESP_OKAY);
        axiRead(32'h20, 32'h1122ABCD, RESP_OKAY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
